// File: rtl/ntt_stage_sequencer_pkg.sv
// Shared types and constants for the NTT stage sequencer and its interface.
package ntt_stage_sequencer_pkg;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned LOG_M_W = 4;

  localparam logic [1:0] MODE_EARLY = 2'd0;
  localparam logic [1:0] MODE_MID   = 2'd1;
  localparam logic [1:0] MODE_LAST  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  function automatic logic [1:0] stage_mode(logic [LOG_M_W-1:0] log_m,
                                            int unsigned mode1_start,
                                            int unsigned mode2_start);
    if (32'(log_m) < mode1_start) return MODE_EARLY;
    if (32'(log_m) < mode2_start) return MODE_MID;
    return MODE_LAST;
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Control bundle between the stage sequencer (master) and the ntt_core (slave).
interface ntt_stage_sequencer_if;
  import ntt_stage_sequencer_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic [LOG_M_W-1:0] log_m;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   i;
  logic [ADDR_W-1:0]  upper_read_address;
  logic [ADDR_W-1:0]  lower_read_address;
  logic               write_enable;
  logic [ADDR_W-1:0]  upper_write_address;
  logic [ADDR_W-1:0]  lower_write_address;

  modport master (
    input  start,
    output busy, done, log_m, mode, i, upper_read_address, lower_read_address,
           write_enable, upper_write_address, lower_write_address
  );

  modport slave (
    output start,
    input  busy, done, log_m, mode, i, upper_read_address, lower_read_address,
           write_enable, upper_write_address, lower_write_address
  );

endinterface

// File: rtl/ntt_addr_delay_line.sv
// Fixed-depth {valid, addr} shift register that realigns issued reads with
// the butterfly outputs they produce.
module ntt_addr_delay_line #(
  parameter int unsigned Depth = 7,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [AddrW-1:0] in_addr,
  output logic             out_valid,
  output logic [AddrW-1:0] out_addr
);

  logic [AddrW:0] pipe_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Depth; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= {in_valid, in_addr};
      for (int k = 1; k < Depth; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign out_valid = pipe_q[Depth-1][AddrW];
  assign out_addr  = pipe_q[Depth-1][AddrW-1:0];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sweeps every NTT stage's word addresses through one core and drains the
// butterfly pipeline between stages so no stage reads stale data.
module ntt_stage_sequencer
  import ntt_stage_sequencer_pkg::*;
#(
  parameter int unsigned WORDS       = 512,
  parameter int unsigned NUM_STAGES  = 12,
  parameter int unsigned MODE1_START = 5,
  parameter int unsigned MODE2_START = 11,
  parameter int unsigned BF_LATENCY  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ntt_stage_sequencer_if.master bus
);

  localparam int unsigned PipeDepth = 1 + BF_LATENCY;
  localparam int unsigned DrainW    = $clog2(PipeDepth) + 1;

  localparam logic [CNT_W-1:0]   LastWord  = CNT_W'(WORDS - 1);
  localparam logic [LOG_M_W-1:0] LastStage = LOG_M_W'(NUM_STAGES - 1);
  localparam logic [DrainW-1:0]  LastDrain = DrainW'(BF_LATENCY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [LOG_M_W-1:0] log_m_q, log_m_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   i_q, i_d;
  logic               issue_q, issue_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    log_m_d = log_m_q;
    mode_d  = mode_q;
    i_d     = i_q;
    issue_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = '0;
          log_m_d = '0;
          mode_d  = stage_mode('0, MODE1_START, MODE2_START);
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        issue_d = 1'b1;
        i_d     = cnt_q;
        if (cnt_q == LastWord) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        // Stage index only moves once the last write of the stage is in its final slot.
        if (drain_q == LastDrain) begin
          if (log_m_q == LastStage) begin
            state_d = StDone;
          end else begin
            log_m_d = log_m_q + 1'b1;
            mode_d  = stage_mode(log_m_q + 1'b1, MODE1_START, MODE2_START);
            cnt_d   = '0;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      log_m_q <= '0;
      mode_q  <= '0;
      i_q     <= '0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      log_m_q <= log_m_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      issue_q <= issue_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;

  ntt_addr_delay_line #(
    .Depth (PipeDepth),
    .AddrW (ADDR_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_q),
    .in_addr   (i_q[ADDR_W-1:0]),
    .out_valid (wr_valid),
    .out_addr  (wr_addr)
  );

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.log_m               = log_m_q;
  assign bus.mode                = mode_q;
  assign bus.i                   = i_q;
  assign bus.upper_read_address  = i_q[ADDR_W-1:0];
  assign bus.lower_read_address  = i_q[ADDR_W-1:0];
  assign bus.write_enable        = wr_valid;
  assign bus.upper_write_address = wr_addr;
  assign bus.lower_write_address = wr_addr;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench: each start pushes timed read/write/done expectations that a
// negedge monitor pops and compares against four differently sized instances.
module tb_ntt_stage_sequencer;
  import ntt_stage_sequencer_pkg::*;

  localparam int NDUT = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] lm;
    logic [1:0] md;
    logic [9:0] i;
    logic [8:0] ura;
    logic [8:0] lra;
    logic       we;
    logic [8:0] uwa;
    logic [8:0] lwa;
  } obs_t;

  typedef struct {
    int         cyc;
    logic [8:0] rd;
    logic [9:0] i;
    logic [3:0] lm;
    logic [1:0] md;
    bit         chk_lm;
  } rd_exp_t;

  typedef struct {
    int         cyc;
    logic [8:0] wa;
  } wr_exp_t;

  // Per-instance configuration: A single stage, B two stages, C mode map, D full depth.
  int cw  [NDUT] = '{4, 4, 2, 512};
  int cns [NDUT] = '{1, 2, 12, 2};
  int cbf [NDUT] = '{2, 2, 6, 6};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s [NDUT];
  obs_t obs [NDUT];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   dones_seen [NDUT];
  int   wes_seen [NDUT];

  rd_exp_t rdq   [NDUT][$];
  wr_exp_t wrq   [NDUT][$];
  int      doneq [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_stage_sequencer_if if_a ();
  ntt_stage_sequencer_if if_b ();
  ntt_stage_sequencer_if if_c ();
  ntt_stage_sequencer_if if_d ();

  assign if_a.start = start_s[0];
  assign if_b.start = start_s[1];
  assign if_c.start = start_s[2];
  assign if_d.start = start_s[3];

  assign obs[0] = {if_a.busy, if_a.done, if_a.log_m, if_a.mode, if_a.i, if_a.upper_read_address,
                   if_a.lower_read_address, if_a.write_enable, if_a.upper_write_address,
                   if_a.lower_write_address};
  assign obs[1] = {if_b.busy, if_b.done, if_b.log_m, if_b.mode, if_b.i, if_b.upper_read_address,
                   if_b.lower_read_address, if_b.write_enable, if_b.upper_write_address,
                   if_b.lower_write_address};
  assign obs[2] = {if_c.busy, if_c.done, if_c.log_m, if_c.mode, if_c.i, if_c.upper_read_address,
                   if_c.lower_read_address, if_c.write_enable, if_c.upper_write_address,
                   if_c.lower_write_address};
  assign obs[3] = {if_d.busy, if_d.done, if_d.log_m, if_d.mode, if_d.i, if_d.upper_read_address,
                   if_d.lower_read_address, if_d.write_enable, if_d.upper_write_address,
                   if_d.lower_write_address};

  ntt_stage_sequencer #(.WORDS(4), .NUM_STAGES(1), .BF_LATENCY(2)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a.master)
  );
  ntt_stage_sequencer #(.WORDS(4), .NUM_STAGES(2), .BF_LATENCY(2)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b.master)
  );
  ntt_stage_sequencer #(.WORDS(2)) u_dut_c (
    .clk (clk), .rst_n (rst_n), .bus (if_c.master)
  );
  ntt_stage_sequencer #(.WORDS(512), .NUM_STAGES(2)) u_dut_d (
    .clk (clk), .rst_n (rst_n), .bus (if_d.master)
  );

  task automatic check(string name, int d, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h required %0h", name, d, cyc, got, exp);
  endtask

  function automatic logic [1:0] exp_mode(int s);
    if (s < 5) return 2'd0;
    if (s < 11) return 2'd1;
    return 2'd2;
  endfunction

  // Reads become visible two cycles after start is sampled; writes 1+BF cycles later.
  task automatic push_run(int d, int c0);
    int w, ns, bf, r0;
    rd_exp_t re;
    wr_exp_t we;
    w  = cw[d];
    ns = cns[d];
    bf = cbf[d];
    for (int s = 0; s < ns; s++) begin
      r0 = c0 + 2 + s * (w + 1 + bf);
      for (int k = 0; k < w; k++) begin
        re = '{cyc: r0 + k, rd: 9'(k), i: 10'(k), lm: 4'(s), md: exp_mode(s), chk_lm: 1'b1};
        rdq[d].push_back(re);
        we = '{cyc: r0 + k + 1 + bf, wa: 9'(k)};
        wrq[d].push_back(we);
      end
      for (int k = 0; k <= bf; k++) begin
        re = '{cyc: r0 + w + k, rd: 9'(w - 1), i: 10'(w - 1), lm: 4'd0, md: 2'd0, chk_lm: 1'b0};
        rdq[d].push_back(re);
      end
    end
    doneq[d].push_back(c0 + ns * (w + 1 + bf) + 2);
  endtask

  task automatic launch(int d);
    @(posedge clk); #1;
    start_s[d] = 1'b1;
    push_run(d, cyc);
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic flush(int d);
    rdq[d].delete();
    wrq[d].delete();
    doneq[d].delete();
  endtask

  task automatic wait_quiet(int d, int budget);
    int k;
    int pending;
    k = 0;
    pending = rdq[d].size() + wrq[d].size() + doneq[d].size();
    while (pending != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
      pending = rdq[d].size() + wrq[d].size() + doneq[d].size();
    end
    check("run_completes_in_budget", d, 64'(pending), 64'd0);
    flush(d);
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    wr_exp_t w;
    for (int d = 0; d < NDUT; d++) begin
      if (obs[d].we) wes_seen[d]++;
      if (obs[d].done) dones_seen[d]++;
      if (rdq[d].size() != 0 && rdq[d][0].cyc == cyc) begin
        e = rdq[d].pop_front();
        check("read_issue", d,
              64'({obs[d].busy, obs[d].ura, obs[d].lra, obs[d].i,
                   e.chk_lm ? obs[d].lm : 4'd0, e.chk_lm ? obs[d].md : 2'd0}),
              64'({1'b1, e.rd, e.rd, e.i, e.lm, e.md}));
      end
      if (wrq[d].size() != 0 && wrq[d][0].cyc == cyc) begin
        w = wrq[d].pop_front();
        check("write_back", d, 64'({obs[d].we, obs[d].uwa, obs[d].lwa}),
              64'({1'b1, w.wa, w.wa}));
      end else if (obs[d].we) begin
        check("stray_write_enable", d, 64'(obs[d].we), 64'd0);
      end
      if (doneq[d].size() != 0 && doneq[d][0] == cyc) begin
        void'(doneq[d].pop_front());
        check("done_pulse", d, 64'({obs[d].done, obs[d].busy}), 64'({1'b1, 1'b0}));
      end else if (obs[d].done) begin
        check("stray_done", d, 64'(obs[d].done), 64'd0);
      end
    end
  end

  initial begin
    int snap;
    for (int d = 0; d < NDUT; d++) begin
      start_s[d] = 1'b0;
      dones_seen[d] = 0;
      wes_seen[d] = 0;
    end
    #12;
    for (int d = 0; d < NDUT; d++) check("reset_outputs", d, 64'(obs[d]), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single stage, with a start pulse ignored mid-run, then a back-to-back restart.
    snap = dones_seen[0];
    launch(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_quiet(0, 50);
    check("exactly_one_done", 0, 64'(dones_seen[0] - snap), 64'd1);
    launch(0);
    wait_quiet(0, 50);

    launch(1);
    wait_quiet(1, 60);
    launch(2);
    wait_quiet(2, 200);
    launch(3);
    wait_quiet(3, 1200);

    // Asynchronous reset in the middle of ISSUE.
    launch(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_issue", 0, 64'(obs[0]), 64'd0);
    flush(0);
    snap = dones_seen[0] + wes_seen[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("quiet_after_reset", 0, 64'(dones_seen[0] + wes_seen[0] - snap), 64'd0);
    launch(0);
    wait_quiet(0, 50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
